reg_file: RTL
=============

Name: reg_file

Overview:
- 2-read / 1-write integer register file for the RV32I single-cycle core.
- Sits directly upstream of the ALU: RD1 drives ALU SrcA; RD2 drives SrcB through the immediate mux.
- Writeback from the result mux lands here on the rising clock edge.
- x0 is hardwired to zero.

Parameters:
- DWIDTH, 32, register data width in bits; must match ALU DWIDTH.
- AWIDTH, 5, register address width; register count NREGS = 2**AWIDTH.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A1  input  AWIDTH  read port 1 address (instruction rs1).
- A2  input  AWIDTH  read port 2 address (instruction rs2).
- A3  input  AWIDTH  write port address (instruction rd).
- WD3  input  DWIDTH  write data from the result mux.
- WE3  input  1  write enable from the control unit (RegWrite).
- RD1  output  DWIDTH  read data 1, to ALU SrcA.
- RD2  output  DWIDTH  read data 2, to ALU SrcB mux.

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous, active-low.
- Storage: NREGS words of DWIDTH bits.
  - Entry 0 is never written; it always reads 0.
  - Entry 0 may be omitted from storage entirely.
- Reset:
  - rst_n low clears entries 1..NREGS-1 to 0 immediately, with no clock edge needed.
  - RD1 and RD2 therefore read 0 during reset for every address.
  - Writes are ignored while rst_n is low.
  - Deassertion is asynchronous. The first write takes effect on the first rising edge with rst_n high.
- Write:
  - On a rising clk with WE3=1 and A3!=0, entry[A3] <= WD3.
  - WE3=0 or A3=0: no state change.
  - Write-to-x0 is silently dropped; no error flag.
- Read:
  - Combinational, zero-latency.
  - RD1 = (A1==0) ? 0 : entry[A1]; RD2 likewise with A2.
  - Reads reflect state after the most recent edge.
- Same-cycle read/write of the same address (no bypass):
  - Read returns the old value during that cycle.
  - The new value is visible after the edge.
  - Single-cycle core is correct under this rule, since the consumer instruction is already in the next cycle.
- Both read ports may address the same entry and return identical data.
- Mid-operation reset:
  - rst_n falling between edges zeroes all outputs within the same delta.
  - A write pending on the next edge is lost if rst_n is still low at that edge.
- X handling:
  - WE3=X or A3=X on an edge is a protocol violation.
  - An assertion flags it in simulation; RTL behaviour is undefined.
- Widths: no sign extension or truncation. WD3 is stored verbatim at DWIDTH bits.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through bypass: if WE3=1 and A3!=0 and A1==A3, RD1 = WD3 combinationally in the same cycle. Same rule for RD2/A2.
  - Intended for the future pipelined variant, where writeback and decode share a cycle.
  - Reset still forces RD1/RD2 to 0, overriding the bypass.
  - A3=0 never bypasses.
- Undefined: same-cycle reads return the old stored value, as described in Behaviour.

Test Plan:
- Reset: preload x5=0x1234_5678, then pulse rst_n low between edges -> RD1 (A1=5) reads 0x0000_0000 immediately, before any clk edge.
- Basic write/read: WE3=1, A3=3, WD3=0x0000_0001; WE3=1, A3=4, WD3=0x0000_0002; then A1=3, A2=4 -> RD1=1, RD2=2. Route into ALU with ALUControl=ADD -> ALUResult=3.
- x0 immutability: WE3=1, A3=0, WD3=0xFFFF_FFFF; then A1=0, A2=0 -> RD1=RD2=0.
- WE3 gating: x7=0xA5A5_A5A5, then WE3=0, A3=7, WD3=0 for one edge -> RD1 (A1=7) still 0xA5A5_A5A5.
- Same-cycle collision: x9=0x10; in the cycle where WE3=1, A3=9, WD3=0x20 with A1=9 -> RD1=0x10 before the edge and 0x20 after. With REGFILE_BYPASS_EN -> RD1=0x20 within the cycle.
- Full sweep: write x[i]=i*0x0101_0101 for i=1..31, then read all pairs (i, 31-i) -> every value matches; x0 reads 0; address 31 holds 0x1F1F_1F1F.

Source files
------------

// File: rtl/reg_file.sv
// 2-read / 1-write integer register file with hardwired-zero x0 and async active-low reset.
// Optional write-through bypass on both read ports when REGFILE_BYPASS_EN is defined.
module reg_file #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] A1,
  input  logic [AWIDTH-1:0] A2,
  input  logic [AWIDTH-1:0] A3,
  input  logic [DWIDTH-1:0] WD3,
  input  logic              WE3,
  output logic [DWIDTH-1:0] RD1,
  output logic [DWIDTH-1:0] RD2
);

  localparam int NREGS = 2 ** AWIDTH;

  logic [DWIDTH-1:0] words [NREGS];
  logic [DWIDTH-1:0] rd1_next;
  logic [DWIDTH-1:0] rd2_next;

  // x0 has no storage; its slot in the read mux is a constant zero.
  assign words[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_word
      logic [DWIDTH-1:0] word_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (WE3 && (A3 == AWIDTH'(gi))) begin
          word_reg <= WD3;
        end
      end

      assign words[gi] = word_reg;
    end
  endgenerate

  always_comb begin
    rd1_next = words[A1];
    rd2_next = words[A2];
`ifdef REGFILE_BYPASS_EN
    if (WE3 && (A3 != '0) && (A1 == A3)) rd1_next = WD3;
    if (WE3 && (A3 != '0) && (A2 == A3)) rd2_next = WD3;
`endif
    // Reset dominates, including over a bypassed write value.
    if (!rst_n) begin
      rd1_next = '0;
      rd2_next = '0;
    end
  end

  assign RD1 = rd1_next;
  assign RD2 = rd2_next;

`ifndef SYNTHESIS
  a_write_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({WE3, A3}));
`endif

endmodule
